gray_seq_ctrl: RTL and testbench

- Sequencer for the binary-to-gray conversion datapath. On `start` it steps a binary value through a programmed inclusive range, up or down, modulo 2^WIDTH.
- Each step is presented as a registered binary/gray pair on a valid/ready stream.
- Feeds downstream consumers such as gray-coded pointers and test pattern sinks.
- Includes a sticky self-check flag that sets if two consecutive accepted gray codes differ by anything other than one bit.

---
 rtl/gray_pkg.sv | 20 ++
 rtl/gray_step_chk.sv | 26 ++
 rtl/gray_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_gray_seq_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared types and helpers for the gray-code sequencer.
package gray_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    // Widest value bin2gray handles; callers cast down to their own width.
    localparam int GRAY_MAX_W = 32;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_step_chk.sv
// Flags whether two gray codes differ in exactly one bit position.
module gray_step_chk #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_prev,
    input  logic [WIDTH-1:0] i_curr,
    output logic             o_one_bit
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] w_diff;
    logic [CW-1:0]    w_cnt;

    assign w_diff = i_prev ^ i_curr;

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt = w_cnt + CW'(w_diff[i]);
        end
    end

    assign o_one_bit = (w_cnt == CW'(1));

endmodule

// File: rtl/gray_seq_ctrl.sv
// Steps a binary value through a modular inclusive range and streams binary/gray pairs.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | presenting beats on the valid/ready stream
//   DONE  | one-cycle done pulse after the final beat
module gray_seq_ctrl
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] first_val,
    input  logic [WIDTH-1:0] last_val,
    input  logic             dir,
    input  logic             abort,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] g_out,
    output logic             last,
    output logic             busy,
    output logic             done,
    output logic             gray_err
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_g;
    logic [WIDTH-1:0] r_last_val;
    logic             r_dir;
    logic [WIDTH-1:0] r_prev_g;
    logic             r_have_prev;
    logic             r_gray_err;

    logic             w_start_go;
    logic             w_accept;
    logic             w_is_last;
    logic [WIDTH-1:0] w_b_step;
    logic [WIDTH-1:0] w_b_next;
    logic [WIDTH-1:0] w_g_next;
    logic             w_one_bit;

    assign w_start_go = (r_state == IDLE) && start;
    // Abort beats a simultaneous handshake: the beat is not counted as accepted.
    assign w_accept   = (r_state == RUN) && ready && !abort;
    assign w_is_last  = (r_state == RUN) && (r_b == r_last_val);
    assign w_b_step   = (r_dir == DIR_DN) ? (r_b - WIDTH'(1)) : (r_b + WIDTH'(1));

    always_comb begin
        w_b_next = r_b;
        if (w_start_go) begin
            w_b_next = first_val;
        end else if (w_accept && !w_is_last) begin
            w_b_next = w_b_step;
        end
    end

    assign w_g_next = WIDTH'(bin2gray(GRAY_MAX_W'(w_b_next)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (start) w_state_nxt = RUN;
            RUN: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (w_accept && w_is_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b        <= '0;
            r_g        <= '0;
            r_last_val <= '0;
            r_dir      <= DIR_UP;
        end else begin
            r_b <= w_b_next;
            r_g <= w_g_next;
            if (w_start_go) begin
                r_last_val <= last_val;
                r_dir      <= dir;
            end
        end
    end

    gray_step_chk #(
        .WIDTH (WIDTH)
    ) u_step_chk (
        .i_prev    (r_prev_g),
        .i_curr    (r_g),
        .o_one_bit (w_one_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_g    <= '0;
            r_have_prev <= 1'b0;
            r_gray_err  <= 1'b0;
        end else if (w_start_go) begin
            r_have_prev <= 1'b0;
            r_gray_err  <= 1'b0;
        end else if (w_accept) begin
            r_prev_g    <= r_g;
            r_have_prev <= 1'b1;
            if (r_have_prev && !w_one_bit) begin
                r_gray_err <= 1'b1;
            end
        end
    end

    assign valid    = (r_state == RUN);
    assign busy     = (r_state == RUN);
    assign done     = (r_state == DONE);
    assign last     = w_is_last;
    assign b_out    = r_b;
    assign g_out    = r_g;
    assign gray_err = r_gray_err;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Directed and randomized checks of gray_seq_ctrl against a range/queue reference model.
module tb_gray_seq_ctrl;

    localparam int W = 4;
    localparam int M = (1 << W);

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] first_val = '0;
    logic [W-1:0] last_val = '0;
    logic         dir = 1'b0;
    logic         abort = 1'b0;
    logic         ready = 1'b0;
    logic         valid;
    logic [W-1:0] b_out;
    logic [W-1:0] g_out;
    logic         last;
    logic         busy;
    logic         done;
    logic         gray_err;

    int tests = 0;
    int fails = 0;

    gray_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .first_val (first_val),
        .last_val  (last_val),
        .dir       (dir),
        .abort     (abort),
        .ready     (ready),
        .valid     (valid),
        .b_out     (b_out),
        .g_out     (g_out),
        .last      (last),
        .busy      (busy),
        .done      (done),
        .gray_err  (gray_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "timeout");
    end

    function automatic int gray_of(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_valid"}, 32'(valid), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_last"}, 32'(last), 0);
        chk({tag, "_done"}, 32'(done), 0);
    endtask

    // mode: 0 = ready always high, 1 = random ready, 2 = fixed toggle pattern
    task automatic run_seq(input int f, input int l, input bit d, input int mode,
                           input bit inj_start, input bit abort_at_start);
        int n;
        int idx;
        int cyc;
        int exp_b;
        bit r;
        int pat[6] = '{1, 0, 0, 1, 0, 1};
        int beats[$];
        n = ((d ? (f - l) : (l - f)) & (M - 1)) + 1;
        for (int k = 0; k < n; k++) begin
            beats.push_back(d ? ((f - k) & (M - 1)) : ((f + k) & (M - 1)));
        end
        @(negedge clk);
        start = 1'b1;
        abort = abort_at_start;
        first_val = W'(f);
        last_val = W'(l);
        dir = d;
        ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 400) begin
            exp_b = beats[idx];
            chk("beat_valid", 32'(valid), 1);
            chk("beat_busy", 32'(busy), 1);
            chk("beat_b_out", 32'(b_out), 32'(exp_b));
            chk("beat_g_out", 32'(g_out), 32'(gray_of(exp_b)));
            chk("beat_last", 32'(last), 32'(idx == n - 1));
            chk("beat_done", 32'(done), 0);
            chk("beat_gray_err", 32'(gray_err), 0);
            case (mode)
                0:       r = 1'b1;
                1:       r = 1'($urandom_range(0, 1));
                default: r = (cyc < 6) ? pat[cyc][0] : 1'b1;
            endcase
            ready = r;
            if (inj_start && cyc == 1) begin
                start = 1'b1;
                first_val = W'($urandom);
                last_val = W'($urandom);
                dir = ~d;
            end
            if (r) idx++;
            cyc++;
            @(negedge clk);
            start = 1'b0;
        end
        chk("beats_accepted", 32'(idx), 32'(n));
        ready = 1'b0;
        chk("end_valid", 32'(valid), 0);
        chk("end_busy", 32'(busy), 0);
        chk("end_last", 32'(last), 0);
        chk("end_done", 32'(done), 1);
        chk("end_gray_err", 32'(gray_err), 0);
        @(negedge clk);
        chk("post_done", 32'(done), 0);
        chk("post_valid", 32'(valid), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_quiet("reset");
        chk("reset_b_out", 32'(b_out), 0);
        chk("reset_g_out", 32'(g_out), 0);
        chk("reset_gray_err", 32'(gray_err), 0);
        rst_n = 1'b1;

        // full range up, wrap up, wrap down
        run_seq(0, 15, 1'b0, 0, 1'b0, 1'b0);
        run_seq(14, 1, 1'b0, 0, 1'b0, 1'b0);
        run_seq(1, 14, 1'b1, 0, 1'b0, 1'b0);

        // backpressure pattern
        run_seq(5, 7, 1'b0, 2, 1'b0, 1'b0);

        // abort while b_out == 4
        @(negedge clk);
        start = 1'b1;
        first_val = 4'd0;
        last_val = 4'd15;
        dir = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("abort_pre_b_out", 32'(b_out), 32'(k));
            @(negedge clk);
        end
        chk("abort_at_b_out", 32'(b_out), 4);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        ready = 1'b0;
        chk_quiet("abort_after");
        @(negedge clk);
        chk("abort_no_done", 32'(done), 0);
        run_seq(2, 6, 1'b0, 0, 1'b0, 1'b0);

        // single beat, start+abort together in idle, start ignored while running
        run_seq(9, 9, 1'b0, 0, 1'b0, 1'b0);
        run_seq(7, 10, 1'b0, 0, 1'b0, 1'b1);
        run_seq(3, 12, 1'b1, 1, 1'b1, 1'b0);

        // asynchronous reset between clock edges
        @(negedge clk);
        start = 1'b1;
        first_val = 4'd0;
        last_val = 4'd15;
        dir = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_quiet("async_rst");
        chk("async_rst_b_out", 32'(b_out), 0);
        chk("async_rst_g_out", 32'(g_out), 0);
        chk("async_rst_gray_err", 32'(gray_err), 0);
        ready = 1'b0;
        @(negedge clk);
        chk_quiet("async_rst_hold");
        rst_n = 1'b1;
        run_seq(3, 3, 1'b0, 0, 1'b0, 1'b0);

        // randomized ranges with random backpressure
        for (int i = 0; i < 12; i++) begin
            run_seq(int'($urandom_range(0, M - 1)), int'($urandom_range(0, M - 1)),
                    1'($urandom_range(0, 1)), 1, 1'(i % 2), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
